// File: rtl/ecc_apb_pkg.sv
// Shared types and constants for the ECC APB initiator: bus width defaults,
// command entry, FSM state encoding and ECC responder register offsets.
package ecc_apb_pkg;

    localparam int unsigned DEFAULT_AMBA_WORD       = 32;
    localparam int unsigned DEFAULT_AMBA_ADDR_WIDTH = 20;

    typedef struct packed {
        logic                               write;
        logic [DEFAULT_AMBA_ADDR_WIDTH-1:0] addr;
        logic [DEFAULT_AMBA_WORD-1:0]       wdata;
    } apb_cmd_t;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS
    } apb_state_t;

    // ECC encoder/decoder responder register map
    localparam logic [DEFAULT_AMBA_ADDR_WIDTH-1:0] ECC_CTRL_OFFSET           = 20'h00000;
    localparam logic [DEFAULT_AMBA_ADDR_WIDTH-1:0] ECC_DATA_IN_OFFSET        = 20'h00004;
    localparam logic [DEFAULT_AMBA_ADDR_WIDTH-1:0] ECC_CODEWORD_WIDTH_OFFSET = 20'h00008;
    localparam logic [DEFAULT_AMBA_ADDR_WIDTH-1:0] ECC_NOISE_OFFSET          = 20'h0000C;
    localparam logic [DEFAULT_AMBA_ADDR_WIDTH-1:0] ECC_DATA_OUT_OFFSET       = 20'h00010;
    localparam logic [DEFAULT_AMBA_ADDR_WIDTH-1:0] ECC_NUM_OF_ERRORS_OFFSET  = 20'h00014;

endpackage

// File: rtl/ecc_apb_master_if.sv
// Command/response handshake plus APB bus of the ECC APB initiator.
// PREADY exists only when ECC_APB_PREADY_EN is defined.
interface ecc_apb_master_if
    import ecc_apb_pkg::*;
#(
    parameter int unsigned AMBA_WORD       = DEFAULT_AMBA_WORD,
    parameter int unsigned AMBA_ADDR_WIDTH = DEFAULT_AMBA_ADDR_WIDTH
);
    logic                       cmd_valid;
    logic                       cmd_ready;
    logic                       cmd_write;
    logic [AMBA_ADDR_WIDTH-1:0] cmd_addr;
    logic [AMBA_WORD-1:0]       cmd_wdata;
    logic                       rsp_valid;
    logic                       rsp_write;
    logic [AMBA_WORD-1:0]       rsp_rdata;
    logic                       busy;
    logic [AMBA_ADDR_WIDTH-1:0] PADDR;
    logic                       PSEL;
    logic                       PENABLE;
    logic                       PWRITE;
    logic [AMBA_WORD-1:0]       PWDATA;
    logic [AMBA_WORD-1:0]       PRDATA;
`ifdef ECC_APB_PREADY_EN
    logic                       PREADY;
`endif

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, PRDATA,
        output cmd_ready, rsp_valid, rsp_write, rsp_rdata, busy,
        output PADDR, PSEL, PENABLE, PWRITE, PWDATA
`ifdef ECC_APB_PREADY_EN
        , input PREADY
`endif
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata, PRDATA,
        input  cmd_ready, rsp_valid, rsp_write, rsp_rdata, busy,
        input  PADDR, PSEL, PENABLE, PWRITE, PWDATA
`ifdef ECC_APB_PREADY_EN
        , output PREADY
`endif
    );

endinterface

// File: rtl/ecc_apb_cmd_fifo.sv
// Synchronous command FIFO with extra-MSB wrapping pointers; full refuses
// a push even when a pop happens in the same cycle.
module ecc_apb_cmd_fifo
    import ecc_apb_pkg::*;
#(
    parameter int unsigned CMD_DEPTH = 4,
    parameter type         entry_t   = apb_cmd_t
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   push,
    input  entry_t din,
    input  logic   pop,
    output entry_t dout,
    output logic   full,
    output logic   empty
);
    localparam int unsigned PW      = $clog2(CMD_DEPTH);
    localparam logic [PW:0] PTR_ONE = (PW+1)'(1);

    entry_t      mem [CMD_DEPTH];
    logic [PW:0] wr_ptr;
    logic [PW:0] rd_ptr;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
    assign dout  = mem[rd_ptr[PW-1:0]];

    always_ff @(posedge clk) begin
        if (push && !full) begin
            mem[wr_ptr[PW-1:0]] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop && !empty) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
        end
    end

endmodule

// File: rtl/ecc_apb_master.sv
// APB initiator for the ECC responder: buffered commands, registered APB
// SETUP/ACCESS sequencing, one response per transfer. Wait states via ECC_APB_PREADY_EN.
module ecc_apb_master
    import ecc_apb_pkg::*;
#(
    parameter int unsigned AMBA_WORD       = DEFAULT_AMBA_WORD,
    parameter int unsigned AMBA_ADDR_WIDTH = DEFAULT_AMBA_ADDR_WIDTH,
    parameter int unsigned CMD_DEPTH       = 4
) (
    input logic              clk,
    input logic              rst,
    ecc_apb_master_if.master bus
);
    typedef struct packed {
        logic                       write;
        logic [AMBA_ADDR_WIDTH-1:0] addr;
        logic [AMBA_WORD-1:0]       wdata;
    } cmd_t;

    cmd_t       push_cmd;
    cmd_t       head;
    logic       push;
    logic       pop;
    logic       full;
    logic       empty;
    logic       done;
    apb_state_t state;
    apb_state_t state_n;

    logic [AMBA_ADDR_WIDTH-1:0] paddr, paddr_n;
    logic                       psel, psel_n;
    logic                       penable, penable_n;
    logic                       pwrite, pwrite_n;
    logic [AMBA_WORD-1:0]       pwdata, pwdata_n;
    logic                       rsp_valid, rsp_valid_n;
    logic                       rsp_write, rsp_write_n;
    logic [AMBA_WORD-1:0]       rsp_rdata, rsp_rdata_n;

    assign push_cmd      = '{write: bus.cmd_write, addr: bus.cmd_addr, wdata: bus.cmd_wdata};
    assign push          = bus.cmd_valid && !full;
    assign bus.cmd_ready = !full;
    assign bus.busy      = !empty || (state != IDLE);

`ifdef ECC_APB_PREADY_EN
    assign done = bus.PREADY;
`else
    assign done = 1'b1;
`endif

    ecc_apb_cmd_fifo #(
        .CMD_DEPTH (CMD_DEPTH),
        .entry_t   (cmd_t)
    ) u_cmd_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .din   (push_cmd),
        .pop   (pop),
        .dout  (head),
        .full  (full),
        .empty (empty)
    );

    always_comb begin
        state_n     = state;
        paddr_n     = paddr;
        psel_n      = psel;
        penable_n   = penable;
        pwrite_n    = pwrite;
        pwdata_n    = pwdata;
        rsp_valid_n = 1'b0;
        rsp_write_n = rsp_write;
        rsp_rdata_n = rsp_rdata;
        pop         = 1'b0;
        case (state)
            IDLE: begin
                if (!empty) begin
                    pop       = 1'b1;
                    paddr_n   = head.addr;
                    pwrite_n  = head.write;
                    pwdata_n  = head.write ? head.wdata : '0;
                    psel_n    = 1'b1;
                    penable_n = 1'b0;
                    state_n   = SETUP;
                end
            end
            SETUP: begin
                penable_n = 1'b1;
                state_n   = ACCESS;
            end
            ACCESS: begin
                if (done) begin
                    rsp_valid_n = 1'b1;
                    rsp_write_n = pwrite;
                    rsp_rdata_n = pwrite ? '0 : bus.PRDATA;
                    penable_n   = 1'b0;
                    // Chain straight into the next SETUP so PSEL never drops between queued transfers
                    if (!empty) begin
                        pop      = 1'b1;
                        paddr_n  = head.addr;
                        pwrite_n = head.write;
                        pwdata_n = head.write ? head.wdata : '0;
                        state_n  = SETUP;
                    end else begin
                        psel_n  = 1'b0;
                        state_n = IDLE;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            paddr     <= '0;
            psel      <= 1'b0;
            penable   <= 1'b0;
            pwrite    <= 1'b0;
            pwdata    <= '0;
            rsp_valid <= 1'b0;
            rsp_write <= 1'b0;
            rsp_rdata <= '0;
        end else begin
            state     <= state_n;
            paddr     <= paddr_n;
            psel      <= psel_n;
            penable   <= penable_n;
            pwrite    <= pwrite_n;
            pwdata    <= pwdata_n;
            rsp_valid <= rsp_valid_n;
            rsp_write <= rsp_write_n;
            rsp_rdata <= rsp_rdata_n;
        end
    end

    assign bus.PADDR     = paddr;
    assign bus.PSEL      = psel;
    assign bus.PENABLE   = penable;
    assign bus.PWRITE    = pwrite;
    assign bus.PWDATA    = pwdata;
    assign bus.rsp_valid = rsp_valid;
    assign bus.rsp_write = rsp_write;
    assign bus.rsp_rdata = rsp_rdata;

endmodule

// File: tb/tb_ecc_apb_master.sv
// Directed bench for ecc_apb_master: reset, single write/read, back-to-back,
// full FIFO, mid-transfer reset and pointer wrap. Stall test under ECC_APB_PREADY_EN.
module tb_ecc_apb_master;
    import ecc_apb_pkg::*;

    localparam int unsigned AW    = 32;
    localparam int unsigned ADW   = 20;
    localparam int unsigned DEPTH = 4;

    typedef struct packed {
        logic        write;
        logic [31:0] rdata;
    } rsp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        use_model;
    logic [31:0] prdata_manual;
    int unsigned compared = 0;
    int unsigned failed   = 0;
    rsp_t        exp_q[$];

    ecc_apb_master_if #(.AMBA_WORD(AW), .AMBA_ADDR_WIDTH(ADW)) bus ();

    ecc_apb_master #(
        .AMBA_WORD       (AW),
        .AMBA_ADDR_WIDTH (ADW),
        .CMD_DEPTH       (DEPTH)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Responder model: read data is a fixed function of the address
    function automatic logic [31:0] rd_model(input logic [19:0] a);
        return {~a[11:0], a};
    endfunction

    assign bus.PRDATA = use_model ? rd_model(bus.PADDR) : prdata_manual;

    task automatic drive_cmd(input logic v, input apb_cmd_t c);
        bus.cmd_valid = v;
        bus.cmd_write = c.write;
        bus.cmd_addr  = c.addr;
        bus.cmd_wdata = c.wdata;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive_cmd(1'b0, '0);
        repeat (3) @(negedge clk);
        compared++;
        if ({bus.PSEL, bus.PENABLE, bus.PWRITE, bus.rsp_valid, bus.rsp_write} !== 5'b0) begin
            failed++;
            $display("FAIL reset_ctrl got=%b exp=00000", {bus.PSEL, bus.PENABLE, bus.PWRITE, bus.rsp_valid, bus.rsp_write});
        end
        compared++;
        if (bus.PADDR !== 20'h0 || bus.PWDATA !== 32'h0 || bus.rsp_rdata !== 32'h0) begin
            failed++;
            $display("FAIL reset_data got paddr=%h pwdata=%h rdata=%h exp all 0", bus.PADDR, bus.PWDATA, bus.rsp_rdata);
        end
        compared++;
        if (bus.cmd_ready !== 1'b1 || bus.busy !== 1'b0) begin
            failed++;
            $display("FAIL reset_ready got ready=%b busy=%b exp ready=1 busy=0", bus.cmd_ready, bus.busy);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_single_write();
        drive_cmd(1'b1, '{write: 1'b1, addr: ECC_DATA_IN_OFFSET, wdata: 32'hDEADBEEF});
        compared++;
        if (bus.cmd_ready !== 1'b1) begin
            failed++; $display("FAIL wr_ready got=%b exp=1", bus.cmd_ready);
        end
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        compared++;
        if (bus.PSEL !== 1'b0 || bus.busy !== 1'b1) begin
            failed++; $display("FAIL wr_n1 got psel=%b busy=%b exp psel=0 busy=1", bus.PSEL, bus.busy);
        end
        @(negedge clk);
        compared++;
        if ({bus.PSEL, bus.PENABLE, bus.PWRITE} !== 3'b101 || bus.PADDR !== 20'h00004 || bus.PWDATA !== 32'hDEADBEEF) begin
            failed++;
            $display("FAIL wr_setup got sel/en/wr=%b paddr=%h pwdata=%h exp 101 00004 deadbeef",
                     {bus.PSEL, bus.PENABLE, bus.PWRITE}, bus.PADDR, bus.PWDATA);
        end
        @(negedge clk);
        compared++;
        if ({bus.PSEL, bus.PENABLE, bus.rsp_valid} !== 3'b110 || bus.PADDR !== 20'h00004) begin
            failed++;
            $display("FAIL wr_access got sel/en/rv=%b paddr=%h exp 110 00004", {bus.PSEL, bus.PENABLE, bus.rsp_valid}, bus.PADDR);
        end
        @(negedge clk);
        compared++;
        if ({bus.rsp_valid, bus.rsp_write} !== 2'b11 || bus.rsp_rdata !== 32'h0 || bus.busy !== 1'b0) begin
            failed++;
            $display("FAIL wr_rsp got rv/rw=%b rdata=%h busy=%b exp 11 00000000 0",
                     {bus.rsp_valid, bus.rsp_write}, bus.rsp_rdata, bus.busy);
        end
        compared++;
        if ({bus.PSEL, bus.PENABLE} !== 2'b00 || bus.PADDR !== 20'h00004 || bus.PWDATA !== 32'hDEADBEEF) begin
            failed++;
            $display("FAIL wr_idle got sel/en=%b paddr=%h pwdata=%h exp 00 00004 deadbeef",
                     {bus.PSEL, bus.PENABLE}, bus.PADDR, bus.PWDATA);
        end
        @(negedge clk);
        compared++;
        if (bus.rsp_valid !== 1'b0) begin
            failed++; $display("FAIL wr_pulse got rsp_valid=%b exp=0", bus.rsp_valid);
        end
    endtask

    task automatic test_single_read();
        use_model     = 1'b0;
        prdata_manual = 32'hFFFF_FFFF;
        drive_cmd(1'b1, '{write: 1'b0, addr: ECC_NOISE_OFFSET, wdata: 32'h1234_5678});
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        @(negedge clk);
        compared++;
        if ({bus.PSEL, bus.PENABLE, bus.PWRITE} !== 3'b100 || bus.PADDR !== 20'h0000C || bus.PWDATA !== 32'h0) begin
            failed++;
            $display("FAIL rd_setup got sel/en/wr=%b paddr=%h pwdata=%h exp 100 0000c 00000000",
                     {bus.PSEL, bus.PENABLE, bus.PWRITE}, bus.PADDR, bus.PWDATA);
        end
        @(negedge clk);
        prdata_manual = 32'h0000_0A5A;
        compared++;
        if ({bus.PSEL, bus.PENABLE} !== 2'b11 || bus.PWDATA !== 32'h0) begin
            failed++;
            $display("FAIL rd_access got sel/en=%b pwdata=%h exp 11 00000000", {bus.PSEL, bus.PENABLE}, bus.PWDATA);
        end
        @(negedge clk);
        prdata_manual = 32'hFFFF_FFFF;
        compared++;
        if ({bus.rsp_valid, bus.rsp_write} !== 2'b10 || bus.rsp_rdata !== 32'h0000_0A5A) begin
            failed++;
            $display("FAIL rd_rsp got rv/rw=%b rdata=%h exp 10 00000a5a", {bus.rsp_valid, bus.rsp_write}, bus.rsp_rdata);
        end
        use_model = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        logic exp_sel, exp_en, exp_rv;
        logic [19:0] exp_addr;
        for (int t = 0; t < 12; t++) begin
            exp_sel = (t >= 2 && t <= 9);
            exp_en  = exp_sel && (t % 2 == 1);
            exp_rv  = (t >= 4 && t <= 10 && t % 2 == 0);
            compared++;
            if ({bus.PSEL, bus.PENABLE, bus.rsp_valid} !== {exp_sel, exp_en, exp_rv}) begin
                failed++;
                $display("FAIL b2b_seq t=%0d got sel/en/rv=%b exp=%b", t, {bus.PSEL, bus.PENABLE, bus.rsp_valid}, {exp_sel, exp_en, exp_rv});
            end
            if (t >= 2 && t <= 8 && t % 2 == 0) begin
                exp_addr = 20'(32'h100 + 2 * (t - 2));
                compared++;
                if (bus.PADDR !== exp_addr || bus.PWDATA !== 32'(32'hA000 + (t - 2) / 2) || bus.PWRITE !== 1'b1) begin
                    failed++;
                    $display("FAIL b2b_addr t=%0d got paddr=%h pwdata=%h exp paddr=%h pwdata=%h", t, bus.PADDR, bus.PWDATA,
                             exp_addr, 32'(32'hA000 + (t - 2) / 2));
                end
            end
            if (exp_rv) begin
                compared++;
                if (bus.rsp_write !== 1'b1 || bus.rsp_rdata !== 32'h0) begin
                    failed++; $display("FAIL b2b_rsp t=%0d got rw=%b rdata=%h exp 1 00000000", t, bus.rsp_write, bus.rsp_rdata);
                end
            end
            if (t < 4) begin
                compared++;
                if (bus.cmd_ready !== 1'b1) begin
                    failed++; $display("FAIL b2b_ready t=%0d got=%b exp=1", t, bus.cmd_ready);
                end
                drive_cmd(1'b1, '{write: 1'b1, addr: 20'(32'h100 + 4 * t), wdata: 32'(32'hA000 + t)});
            end else begin
                bus.cmd_valid = 1'b0;
            end
            @(negedge clk);
        end
    endtask

    // Pushing every cycle against a 2-cycle drain fills the FIFO at cycle 7;
    // the pop at the end of that cycle must not let the refused push through.
    task automatic test_full();
        apb_cmd_t c;
        rsp_t     r;
        int       k = 0;
        for (int t = 0; t < 80 && !(t > 10 && k == 9 && exp_q.size() == 0); t++) begin
            if (bus.rsp_valid === 1'b1) begin
                compared++;
                if (exp_q.size() == 0) begin
                    failed++; $display("FAIL full_rsp t=%0d got unexpected response exp none", t);
                end else begin
                    r = exp_q.pop_front();
                    if (bus.rsp_write !== r.write || bus.rsp_rdata !== r.rdata) begin
                        failed++;
                        $display("FAIL full_rsp t=%0d got rw=%b rdata=%h exp rw=%b rdata=%h", t, bus.rsp_write, bus.rsp_rdata, r.write, r.rdata);
                    end
                end
            end
            if (t <= 10) begin
                compared++;
                if (bus.cmd_ready !== !(t == 7 || t == 9)) begin
                    failed++; $display("FAIL full_ready t=%0d got=%b exp=%b", t, bus.cmd_ready, !(t == 7 || t == 9));
                end
            end
            if (k < 9) begin
                c = '{write: (k % 2 == 0), addr: 20'(32'h200 + 4 * k), wdata: 32'(32'hF000_0000 + k)};
                drive_cmd(1'b1, c);
                if (bus.cmd_ready === 1'b1) begin
                    exp_q.push_back('{write: c.write, rdata: c.write ? 32'h0 : rd_model(c.addr)});
                    k++;
                end
            end else begin
                bus.cmd_valid = 1'b0;
            end
            @(negedge clk);
        end
        compared++;
        if (k != 9 || exp_q.size() != 0 || bus.busy !== 1'b0) begin
            failed++; $display("FAIL full_drain got accepted=%0d pending=%0d busy=%b exp 9 0 0", k, exp_q.size(), bus.busy);
        end
        exp_q.delete();
    endtask

`ifdef ECC_APB_PREADY_EN
    task automatic test_stall();
        apb_cmd_t c;
        rsp_t     r;
        int       k = 1;
        bus.PREADY = 1'b0;
        c = '{write: 1'b1, addr: 20'h00300, wdata: 32'h5555_AAAA};
        drive_cmd(1'b1, c);
        exp_q.push_back('{write: 1'b1, rdata: 32'h0});
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        repeat (2) @(negedge clk);
        for (int s = 0; s < 8; s++) begin
            compared++;
            if ({bus.PSEL, bus.PENABLE, bus.PWRITE, bus.PADDR, bus.PWDATA, bus.rsp_valid} !== {3'b111, 20'h00300, 32'h5555_AAAA, 1'b0}) begin
                failed++;
                $display("FAIL stall_hold s=%0d got sel/en/wr=%b paddr=%h pwdata=%h rv=%b exp 111 00300 5555aaaa 0", s,
                         {bus.PSEL, bus.PENABLE, bus.PWRITE}, bus.PADDR, bus.PWDATA, bus.rsp_valid);
            end
            compared++;
            if (bus.cmd_ready !== (s < 4)) begin
                failed++; $display("FAIL stall_ready s=%0d got=%b exp=%b", s, bus.cmd_ready, (s < 4));
            end
            c = '{write: (k % 2 == 1), addr: 20'(32'h300 + 4 * k), wdata: 32'(32'h7000 + k)};
            drive_cmd(1'b1, c);
            if (bus.cmd_ready === 1'b1) begin
                exp_q.push_back('{write: c.write, rdata: c.write ? 32'h0 : rd_model(c.addr)});
                k++;
            end
            @(negedge clk);
        end
        bus.PREADY = 1'b1;
        for (int t = 0; t < 60 && !(k == 7 && exp_q.size() == 0); t++) begin
            if (bus.rsp_valid === 1'b1) begin
                compared++;
                r = exp_q.pop_front();
                if (bus.rsp_write !== r.write || bus.rsp_rdata !== r.rdata) begin
                    failed++;
                    $display("FAIL stall_rsp t=%0d got rw=%b rdata=%h exp rw=%b rdata=%h", t, bus.rsp_write, bus.rsp_rdata, r.write, r.rdata);
                end
            end
            if (k < 7) begin
                c = '{write: (k % 2 == 1), addr: 20'(32'h300 + 4 * k), wdata: 32'(32'h7000 + k)};
                drive_cmd(1'b1, c);
                if (bus.cmd_ready === 1'b1) begin
                    exp_q.push_back('{write: c.write, rdata: c.write ? 32'h0 : rd_model(c.addr)});
                    k++;
                end
            end else begin
                bus.cmd_valid = 1'b0;
            end
            @(negedge clk);
        end
        compared++;
        if (k != 7 || exp_q.size() != 0) begin
            failed++; $display("FAIL stall_drain got accepted=%0d pending=%0d exp 7 0", k, exp_q.size());
        end
        exp_q.delete();
    endtask
`endif

    task automatic test_reset_midop();
        for (int t = 0; t < 3; t++) begin
            drive_cmd(1'b1, '{write: 1'b1, addr: 20'(32'h400 + 4 * t), wdata: 32'(32'hB000 + t)});
            @(negedge clk);
        end
        bus.cmd_valid = 1'b0;
        compared++;
        if ({bus.PSEL, bus.PENABLE} !== 2'b11) begin
            failed++; $display("FAIL rstmid_access got sel/en=%b exp=11", {bus.PSEL, bus.PENABLE});
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        compared++;
        if ({bus.PSEL, bus.PENABLE, bus.busy, bus.cmd_ready, bus.rsp_valid} !== 5'b00010) begin
            failed++;
            $display("FAIL rstmid_state got sel/en/busy/ready/rv=%b exp=00010", {bus.PSEL, bus.PENABLE, bus.busy, bus.cmd_ready, bus.rsp_valid});
        end
        for (int t = 0; t < 6; t++) begin
            @(negedge clk);
            compared++;
            if ({bus.PSEL, bus.rsp_valid, bus.busy} !== 3'b000) begin
                failed++; $display("FAIL rstmid_quiet t=%0d got sel/rv/busy=%b exp=000", t, {bus.PSEL, bus.rsp_valid, bus.busy});
            end
        end
    endtask

    task automatic test_wrap();
        apb_cmd_t cmds[13];
        rsp_t     r;
        int       k = 0;
        for (int i = 0; i < 13; i++) begin
            cmds[i].write = (i % 2 == 0);
            cmds[i].addr  = 20'($urandom);
            cmds[i].wdata = $urandom;
        end
        for (int t = 0; t < 200 && !(k == 13 && exp_q.size() == 0); t++) begin
            if (bus.rsp_valid === 1'b1) begin
                compared++;
                if (exp_q.size() == 0) begin
                    failed++; $display("FAIL wrap_rsp t=%0d got unexpected response exp none", t);
                end else begin
                    r = exp_q.pop_front();
                    if (bus.rsp_write !== r.write || bus.rsp_rdata !== r.rdata) begin
                        failed++;
                        $display("FAIL wrap_rsp t=%0d got rw=%b rdata=%h exp rw=%b rdata=%h", t, bus.rsp_write, bus.rsp_rdata, r.write, r.rdata);
                    end
                end
            end
            if (k < 13) begin
                drive_cmd(1'b1, cmds[k]);
                if (bus.cmd_ready === 1'b1) begin
                    exp_q.push_back('{write: cmds[k].write, rdata: cmds[k].write ? 32'h0 : rd_model(cmds[k].addr)});
                    k++;
                end
            end else begin
                bus.cmd_valid = 1'b0;
            end
            @(negedge clk);
        end
        compared++;
        if (k != 13 || exp_q.size() != 0) begin
            failed++; $display("FAIL wrap_drain got accepted=%0d pending=%0d exp 13 0", k, exp_q.size());
        end
        exp_q.delete();
    endtask

    initial begin
        use_model     = 1'b1;
        prdata_manual = 32'h0;
`ifdef ECC_APB_PREADY_EN
        bus.PREADY    = 1'b1;
`endif
        test_reset();
        test_single_write();
        test_single_read();
        test_back_to_back();
        test_full();
`ifdef ECC_APB_PREADY_EN
        test_stall();
`endif
        test_reset_midop();
        test_wrap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
        $finish;
    end

endmodule

// File: doc/ecc_apb_master.md
Name: ecc_apb_master

Overview:
APB initiator that drives the ECC encoder/decoder's APB responder port, used by the test harness and by future on-chip sequencers.
- Accepts read/write commands on a valid/ready interface and buffers them in a small command FIFO.
- Issues each command as a standard APB SETUP/ACCESS transfer.
- Returns one response (read data) per completed transfer.

Parameters:
AMBA_WORD, 32, APB data width (PWDATA/PRDATA)
AMBA_ADDR_WIDTH, 20, APB address width
CMD_DEPTH, 4, command FIFO entries; power of two, >=2

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous, active-high reset
cmd_valid  in  1  command offered
cmd_ready  out  1  FIFO can accept; equals !fifo_full
cmd_write  in  1  1=write, 0=read
cmd_addr  in  AMBA_ADDR_WIDTH  target address
cmd_wdata  in  AMBA_WORD  write data (ignored for reads)
rsp_valid  out  1  one-cycle pulse per completed transfer
rsp_write  out  1  direction of the completed transfer
rsp_rdata  out  AMBA_WORD  PRDATA captured for reads, 0 for writes
busy  out  1  FIFO non-empty or FSM not IDLE
PADDR  out  AMBA_ADDR_WIDTH  APB address
PSEL  out  1  APB select
PENABLE  out  1  APB enable
PWRITE  out  1  APB direction
PWDATA  out  AMBA_WORD  APB write data
PRDATA  in  AMBA_WORD  APB read data
PREADY  in  1  APB ready; present only with ECC_APB_PREADY_EN

Behaviour:
- Reset (rst=1 at an edge): FIFO emptied; FSM to IDLE. PSEL, PENABLE, PWRITE, PADDR, PWDATA, rsp_valid, rsp_write and rsp_rdata all 0. cmd_ready=1 after reset.
- Reset mid-transfer aborts the transfer: no response, buffered commands are lost.
- Push: when cmd_valid && cmd_ready, entry {write, addr, wdata} is stored at the end of the cycle.
- cmd_ready depends only on fullness. A full FIFO refuses a push even if a pop occurs in the same cycle (no bypass).
- Pointers are log2(CMD_DEPTH)+1 bits and wrap naturally.
- FSM states: IDLE, SETUP, ACCESS. All APB outputs are registered.
- IDLE: if FIFO non-empty, pop the head and load PADDR/PWRITE/PWDATA; set PSEL=1, PENABLE=0; go to SETUP. PWDATA is driven 0 for reads.
- SETUP: set PENABLE=1; go to ACCESS. PADDR, PWRITE and PWDATA are held stable.
- ACCESS completes this cycle (without PREADY, ACCESS always completes in one cycle). On completion:
  - capture PRDATA into rsp_rdata if a read; otherwise rsp_rdata=0;
  - rsp_valid=1 and rsp_write=PWRITE next cycle;
  - if the FIFO is non-empty, pop and go directly to SETUP (PSEL stays 1, PENABLE=0, new address/data);
  - otherwise PSEL=0, PENABLE=0, go to IDLE. PADDR and PWDATA keep their last values.
- Latency: command accepted in cycle N with FIFO empty and FSM IDLE gives SETUP visible N+2, ACCESS N+3, rsp_valid N+4.
- Sustained throughput is 2 cycles per transfer.
- Simultaneous push and pop on a non-full FIFO both take effect; occupancy is unchanged.
- rsp_valid has no backpressure. The consumer must take the response in its pulse cycle.

Optional Feature:
- Macro ECC_APB_PREADY_EN.
- Defined: PREADY port exists. ACCESS holds all APB outputs stable until PREADY=1, and completion happens in the cycle PREADY=1 is sampled.
- Not defined: no PREADY port; every ACCESS completes in one cycle. This matches the ECC responder, which has no wait states.

Decomposition:
- Package ecc_apb_pkg holds:
  - AMBA_WORD and AMBA_ADDR_WIDTH defaults;
  - typedef apb_cmd_t struct {write, addr, wdata};
  - enum apb_state_t {IDLE, SETUP, ACCESS};
  - ECC register offset constants for bench use.
- One sub-module, ecc_apb_cmd_fifo: synchronous FIFO of apb_cmd_t, parameter CMD_DEPTH, outputs full/empty, registered storage.

Test Plan:
- Single write: cmd write addr=0x00004 wdata=0xDEADBEEF at N -> PSEL=1/PENABLE=0 at N+2 with PADDR=0x00004, PWDATA=0xDEADBEEF, PWRITE=1; PENABLE=1 at N+3; rsp_valid at N+4 with rsp_write=1, rsp_rdata=0; busy=0 at N+4.
- Single read: cmd read addr=0x0000C, PRDATA=0x0000_0A5A during ACCESS -> rsp_valid with rsp_rdata=0x0000_0A5A, PWDATA=0 throughout the transfer.
- Back-to-back: push 4 writes in 4 consecutive cycles (CMD_DEPTH=4) -> ACCESS->SETUP without an IDLE gap; SETUP/ACCESS alternate for 8 cycles; 4 rsp_valid pulses 2 cycles apart, in order.
- Full: push 6 commands while FSM is stalled in ACCESS with PREADY=0 (ECC_APB_PREADY_EN) -> cmd_ready=0 after 4 accepted; 5th held until a pop; APB outputs stable during the stall.
- Reset mid-op: assert rst during ACCESS with 2 queued -> next cycle PSEL=PENABLE=0, busy=0, cmd_ready=1, no rsp_valid.
- Wrap: issue 3*CMD_DEPTH+1 alternating read/write commands with random addresses -> all responses in order, matching a reference queue model.
